mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the processor's instruction-fetch requester (I) and its load/store requester (D).
- Issues one transaction at a time.
- Sequences the read-latency wait and routes read data back to the requester that issued the read.
- Gives D priority, with a starvation limit that guarantees I forward progress. It sits between the processor core and the unified memory.

Parameters:
- MEM_LATENCY, 1, cycles from accepted read (m_en=1, m_we=0) to valid m_rdata; legal range 1..4.
- STARVE_LIMIT, 4, consecutive D grants allowed while i_req is high before I is forced; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- i_req  in  1  fetch read request; held with i_addr until i_gnt
- i_addr  in  32  fetch address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch read data valid (1-cycle pulse)
- i_rdata  out  32  fetch read data
- d_req  in  1  load/store request; held with payload until d_gnt
- d_we  in  1  1=store, 0=load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid (1-cycle pulse)
- d_rdata  out  32  load data
- m_en  out  1  memory access strobe
- m_we  out  1  memory write enable
- m_addr  out  32  memory address
- m_wdata  out  32  memory write data
- m_rdata  in  32  memory read data, valid MEM_LATENCY cycles after read issue
- busy  out  1  read outstanding (state WAIT)

Behaviour:
- Reset: clk and reset are fixed as stated: reset is synchronous and active-high on clk.
  - While reset is high, state=IDLE, owner=I, wait counter=0, starve counter=0.
  - While reset is high, all outputs are 0, including the combinational grants.
- FSM has two states, IDLE and WAIT.
- IDLE: grant decision is combinational from the requests and the starve counter.
  - No request: all gnt=0, m_en=0, m_addr=0, m_wdata=0.
  - Only one of i_req/d_req high: that requester is granted.
  - Both high, starve counter < STARVE_LIMIT: D is granted.
  - Both high, starve counter == STARVE_LIMIT: I is granted.
- A granted cycle drives m_en=1 and m_addr/m_we/m_wdata from the winner. I always drives m_we=0 and m_wdata=0.
- Store grant (D, d_we=1): completes in the grant cycle with no rvalid. FSM stays IDLE, so back-to-back stores run at one per cycle.
- Read grant (I, or D with d_we=0):
  - owner is latched, wait counter is loaded with MEM_LATENCY, and the FSM moves to WAIT.
- WAIT:
  - No grants; gnt=0, m_en=0.
  - The counter decrements each cycle.
  - In the cycle the counter equals 1 (the MEM_LATENCY-th cycle after the grant), the owner's rvalid=1 and its rdata=m_rdata (combinational pass-through); then the FSM returns to IDLE.
  - The other port's rdata stays 0.
- Timing: a read granted in cycle t gives rvalid in cycle t+MEM_LATENCY, and the next grant is possible in cycle t+MEM_LATENCY+1.
- Starve counter (4-bit, saturating at STARVE_LIMIT):
  - increments on a D grant while i_req=1;
  - clears on an I grant;
  - clears in any cycle with i_req=0.
- The grant is an accept: the requester may change req/payload in the cycle after gnt.
- Reset mid-WAIT: the in-flight read is discarded, no rvalid is produced, and the FSM returns to IDLE next cycle.
- Addresses and data are passed through unmodified; no alignment checks.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state encoding (IDLE, WAIT);
  - the owner encoding (OWN_I=0, OWN_D=1);
  - the legal MEM_LATENCY/STARVE_LIMIT bounds used for elaboration checks.
- One natural sub-module is arb_starve_cnt: the saturating starvation counter with inc/clear/limit-reached outputs.
- FSM and muxing stay in the top.

Test Plan:
- Fetch read, MEM_LATENCY=1: reset, then i_req=1 with i_addr=0x10 in cycle 0.
  - Cycle 0: i_gnt=1, m_en=1, m_we=0, m_addr=0x10.
  - Cycle 1: memory drives m_rdata=0xDEADBEEF, giving i_rvalid=1 and i_rdata=0xDEADBEEF; d_rvalid=0.
  - Cycle 2: a new grant is possible.
- Store burst: d_req=1, d_we=1 with addresses 0x40, 0x44, 0x48 and wdata 0x1234, 0x5678, 0x9ABC held over 3 cycles.
  - d_gnt=1 and m_we=1 every cycle with matching m_addr/m_wdata; no rvalid; busy=0.
- Contention: i_req and d_req (load, 0x80) both high at cycle 0.
  - Cycle 0: d_gnt=1.
  - Cycle 1: d_rvalid=1.
  - Cycle 2: i_gnt=1.
  - Cycle 3: i_rvalid=1.
- Starvation, STARVE_LIMIT=4: i_req held high and d_req stores continuous.
  - Cycles 0-3: d_gnt=1.
  - Cycle 4: i_gnt=1 and d_gnt=0.
  - Cycle 5 (WAIT): no grants.
  - Cycle 6: d_gnt resumes.
- Reset mid-read, MEM_LATENCY=3: D load granted at t, reset high at t+1.
  - No d_rvalid at t+3.
  - Outputs 0 during reset; the first grant after reset deasserts is honoured.
- Latency, MEM_LATENCY=3: fetch read granted at t.
  - busy=1 and no grants during t+1..t+3, even with d_req high.
  - i_rvalid=1 only at t+3.
  - d_gnt at t+4.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and elaboration bounds for the I/D memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {StIdle = 1'b0, StWait = 1'b1} arb_state_e;

    typedef enum logic {OwnI = 1'b0, OwnD = 1'b1} arb_owner_e;

    localparam int unsigned MinMemLatency  = 1;
    localparam int unsigned MaxMemLatency  = 4;
    localparam int unsigned MinStarveLimit = 1;
    localparam int unsigned MaxStarveLimit = 15;

    localparam int unsigned WaitCntW   = 3;
    localparam int unsigned StarveCntW = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-side signals of the arbiter.
// The master view belongs to the arbiter; the slave view to the core and memory.
interface mem_port_arbiter_if;

    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic        m_en;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    logic        busy;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output m_en, m_we, m_addr, m_wdata, busy
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  m_en, m_we, m_addr, m_wdata, busy
    );

endinterface

// File: rtl/arb_starve_cnt.sv
// Saturating count of D grants taken while I was waiting.
// limit_o forces the next contended grant to I.
module arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic limit_o
);

    localparam logic [StarveCntW-1:0] Limit = StarveCntW'(STARVE_LIMIT);

    logic [StarveCntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != Limit)) begin
            cnt_d = cnt_q + StarveCntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign limit_o = (cnt_q == Limit);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between fetch (I) and load/store (D).
// One transaction at a time; reads hold the port until their data returns.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic                clk,
    input logic                reset,
    mem_port_arbiter_if.master bus
);

    if ((MEM_LATENCY < MinMemLatency) || (MEM_LATENCY > MaxMemLatency)) begin : g_bad_latency
        $error("mem_port_arbiter: MEM_LATENCY out of range");
    end
    if ((STARVE_LIMIT < MinStarveLimit) || (STARVE_LIMIT > MaxStarveLimit)) begin : g_bad_limit
        $error("mem_port_arbiter: STARVE_LIMIT out of range");
    end

    localparam logic [WaitCntW-1:0] LatInit = WaitCntW'(MEM_LATENCY);

    arb_state_e            state_q, state_d;
    arb_owner_e            owner_q, owner_d;
    logic [WaitCntW-1:0]   wait_q, wait_d;
    logic                  starve_lim;

    logic        i_gnt, d_gnt, i_rvalid, d_rvalid, m_en, m_we, busy;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        wait_d   = wait_q;
        i_gnt    = 1'b0;
        d_gnt    = 1'b0;
        m_en     = 1'b0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
        i_rdata  = '0;
        d_rdata  = '0;
        busy     = 1'b0;
        // Reset gates the combinational grants too, so nothing leaks while it is held.
        if (!reset) begin
            unique case (state_q)
                StIdle: begin
                    if (bus.d_req && !(bus.i_req && starve_lim)) begin
                        d_gnt   = 1'b1;
                        m_en    = 1'b1;
                        m_we    = bus.d_we;
                        m_addr  = bus.d_addr;
                        m_wdata = bus.d_wdata;
                        if (!bus.d_we) begin
                            owner_d = OwnD;
                            wait_d  = LatInit;
                            state_d = StWait;
                        end
                    end else if (bus.i_req) begin
                        i_gnt   = 1'b1;
                        m_en    = 1'b1;
                        m_addr  = bus.i_addr;
                        owner_d = OwnI;
                        wait_d  = LatInit;
                        state_d = StWait;
                    end
                end
                StWait: begin
                    busy   = 1'b1;
                    wait_d = wait_q - WaitCntW'(1);
                    if (wait_q == WaitCntW'(1)) begin
                        state_d = StIdle;
                        if (owner_q == OwnD) begin
                            d_rvalid = 1'b1;
                            d_rdata  = bus.m_rdata;
                        end else begin
                            i_rvalid = 1'b1;
                            i_rdata  = bus.m_rdata;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            owner_q <= OwnI;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wait_q  <= wait_d;
        end
    end

    arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (d_gnt & bus.i_req),
        .clr_i   (i_gnt | ~bus.i_req),
        .limit_o (starve_lim)
    );

    assign bus.i_gnt    = i_gnt;
    assign bus.i_rvalid = i_rvalid;
    assign bus.i_rdata  = i_rdata;
    assign bus.d_gnt    = d_gnt;
    assign bus.d_rvalid = d_rvalid;
    assign bus.d_rdata  = d_rdata;
    assign bus.m_en     = m_en;
    assign bus.m_we     = m_we;
    assign bus.m_addr   = m_addr;
    assign bus.m_wdata  = m_wdata;
    assign bus.busy     = busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a cycle-numbered transaction model
// with a word-addressed memory image.
module tb_mem_port_arbiter;

    localparam int unsigned LAT    = 3;
    localparam int unsigned LIM    = 4;
    localparam int          NCYC   = 2400;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .MEM_LATENCY  (LAT),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=0x%08h expected=0x%08h", tag, cyc, got, exp);
        end
    endtask

    // Memory image kept by the model; unwritten words read as zero.
    logic [31:0] mem_m [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return 32'h0;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 15)) << 2;
        return a | 32'h0000_1000;
    endfunction

    // Model state: the port is free from cycle free_at on; one read may be in flight.
    int          free_at;
    bit          rd_pend;
    int          rd_due;
    bit          rd_own_d;
    logic [31:0] rd_data;
    int          starve;
    bit          i_pend, d_pend;

    logic        e_i_gnt, e_d_gnt, e_m_en, e_m_we, e_i_rv, e_d_rv, e_busy;
    logic [31:0] e_m_addr, e_m_wdata, e_i_rd, e_d_rd;

    initial begin
        int p_i, p_d, p_st;
        reset       = 1'b1;
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.m_rdata = '0;
        free_at = 0;
        rd_pend = 0;
        rd_due  = 0;
        rd_own_d = 0;
        rd_data = '0;
        starve  = 0;
        i_pend  = 0;
        d_pend  = 0;

        for (int n = 0; n < NCYC; n++) begin
            @(posedge clk);
            #1;
            cyc = n;
            unique case ((n / 400) % 4)
                0: begin p_i = 50;  p_d = 50;  p_st = 50; end
                1: begin p_i = 90;  p_d = 100; p_st = 90; end
                2: begin p_i = 20;  p_d = 20;  p_st = 30; end
                default: begin p_i = 100; p_d = 60; p_st = 10; end
            endcase
            reset = (n < 3) || ($urandom_range(0, 79) == 0);

            if (!i_pend) begin
                bus.i_addr = rand_addr();
                if ($urandom_range(0, 99) < p_i) i_pend = 1;
            end
            if (!d_pend) begin
                bus.d_addr  = rand_addr();
                bus.d_wdata = $urandom();
                bus.d_we    = ($urandom_range(0, 99) < p_st);
                if ($urandom_range(0, 99) < p_d) d_pend = 1;
            end
            bus.i_req = i_pend;
            bus.d_req = d_pend;
            bus.m_rdata = (rd_pend && (n == rd_due)) ? rd_data : $urandom();

            e_i_gnt = 0; e_d_gnt = 0; e_m_en = 0; e_m_we = 0;
            e_i_rv = 0; e_d_rv = 0; e_busy = 0;
            e_m_addr = '0; e_m_wdata = '0; e_i_rd = '0; e_d_rd = '0;

            if (reset) begin
                rd_pend = 0;
                free_at = 0;
                starve  = 0;
            end else begin
                if (n < free_at) begin
                    e_busy = 1;
                    if (rd_pend && (n == rd_due)) begin
                        rd_pend = 0;
                        if (rd_own_d) begin e_d_rv = 1; e_d_rd = rd_data; end
                        else begin e_i_rv = 1; e_i_rd = rd_data; end
                    end
                end else if (d_pend && (!i_pend || (starve < int'(LIM)))) begin
                    e_d_gnt = 1; e_m_en = 1; e_m_we = bus.d_we;
                    e_m_addr = bus.d_addr; e_m_wdata = bus.d_wdata;
                    if (bus.d_we) begin
                        mem_m[bus.d_addr] = bus.d_wdata;
                    end else begin
                        rd_pend = 1; rd_own_d = 1; rd_due = n + int'(LAT);
                        rd_data = mem_rd(bus.d_addr);
                        free_at = n + int'(LAT) + 1;
                    end
                end else if (i_pend) begin
                    e_i_gnt = 1; e_m_en = 1; e_m_addr = bus.i_addr;
                    rd_pend = 1; rd_own_d = 0; rd_due = n + int'(LAT);
                    rd_data = mem_rd(bus.i_addr);
                    free_at = n + int'(LAT) + 1;
                end
                if (!i_pend || e_i_gnt) starve = 0;
                else if (e_d_gnt && (starve < int'(LIM))) starve++;
            end

            @(negedge clk);
            check_eq("i_gnt",    32'(bus.i_gnt),    32'(e_i_gnt));
            check_eq("d_gnt",    32'(bus.d_gnt),    32'(e_d_gnt));
            check_eq("m_en",     32'(bus.m_en),     32'(e_m_en));
            check_eq("m_we",     32'(bus.m_we),     32'(e_m_we));
            check_eq("m_addr",   bus.m_addr,        e_m_addr);
            check_eq("m_wdata",  bus.m_wdata,       e_m_wdata);
            check_eq("i_rvalid", 32'(bus.i_rvalid), 32'(e_i_rv));
            check_eq("i_rdata",  bus.i_rdata,       e_i_rd);
            check_eq("d_rvalid", 32'(bus.d_rvalid), 32'(e_d_rv));
            check_eq("d_rdata",  bus.d_rdata,       e_d_rd);
            check_eq("busy",     32'(bus.busy),     32'(e_busy));

            if (e_i_gnt) i_pend = 0;
            if (e_d_gnt) d_pend = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
